// File: rtl/peak_list_reader.sv
// -----------------------------------------------------------------------------
// peak_list_reader
//
// Consumer end of the peak-detector output stream. Each 32-bit peak word is
// {peak, side, index}. One frame's peaks (a frame ends on last_out) are
// collected into one half of a ping-pong buffer. Every completed frame is then
// replayed to the host over a valid/ready stream, one beat every two cycles.
//
// Frame hand-off rules:
//   - The write bank is the bank not held by the read side. A completed frame
//     is published into it and the write bank toggles.
//   - If both banks are held by the read side, the incoming frame has nowhere
//     to go. It is discarded, frame_drop pulses and frames_dropped counts it.
//   - A bank whose final beat is accepted in the same cycle as last_out counts
//     as free in that cycle.
//
// Ports
//   clk            rising-edge clock
//   areset         synchronous reset, active high
//   p_valid        p_i_s carries a peak this cycle
//   p_i_s          packed peak word {peak, side, index}
//   last_out       frame end; a same-cycle p_valid word belongs to this frame
//   rd_valid       rd_* fields hold a valid peak
//   rd_ready       host accepts the beat
//   rd_peak        unpacked peak value
//   rd_side        unpacked side bit
//   rd_index       unpacked index
//   rd_last        final peak of the frame being replayed
//   rd_count       number of entries in the frame being replayed
//   rd_trunc       the frame being replayed lost peaks beyond DEPTH
//   frame_drop     one-cycle pulse: a completed frame was discarded
//   frames_dropped saturating count of discarded frames
// -----------------------------------------------------------------------------
module peak_list_reader #(
  parameter int VALUE_WIDTH = 16,
  parameter int INDEX_WIDTH = 15,
  parameter int DEPTH       = 64,
  parameter int CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     areset,
  input  logic                     p_valid,
  input  logic [31:0]              p_i_s,
  input  logic                     last_out,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [VALUE_WIDTH-1:0]   rd_peak,
  output logic                     rd_side,
  output logic [INDEX_WIDTH-1:0]   rd_index,
  output logic                     rd_last,
  output logic [$clog2(DEPTH):0]   rd_count,
  output logic                     rd_trunc,
  output logic                     frame_drop,
  output logic [CNT_W-1:0]         frames_dropped
);

  localparam int AW       = $clog2(DEPTH);
  localparam int CW       = AW + 1;
  localparam int SIDE_BIT = 31 - VALUE_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_SHOW
  } rd_state_t;

  // Both banks live in one array; the bank number is the top address bit.
  logic [31:0]    mem [2*DEPTH];

  // Write side
  logic           wr_bank;
  logic [CW-1:0]  wr_ptr;
  logic           wr_trunc;
  logic           wr_blocked;   // a word of this frame arrived while no bank was free

  // Per-bank frame descriptors
  logic [1:0]     bank_full;
  logic [CW-1:0]  bank_count [2];
  logic [1:0]     bank_trunc;

  // Read side
  rd_state_t      state_q, state_d;
  logic           rd_bank;
  logic [CW-1:0]  rd_ptr;
  logic [31:0]    rd_word;
  logic [CW-1:0]  rd_count_q;
  logic           rd_trunc_q;
  logic           frame_drop_q;
  logic [CNT_W-1:0] drop_cnt;

  // Combinational decisions
  logic           handshake;
  logic           last_beat;
  logic           free_now;
  logic           wr_bank_avail;
  logic           has_room;
  logic           wr_en;
  logic           blocked_now;
  logic [CW-1:0]  frame_len;
  logic           frame_end;
  logic           publish;
  logic           drop;
  logic           trunc_final;
  logic           advance;
  logic           finish;
  logic [AW:0]    wr_addr;
  logic [AW:0]    rd_addr;

  assign rd_valid  = (state_q == S_SHOW);
  assign handshake = rd_valid & rd_ready;
  assign last_beat = (rd_ptr == rd_count_q - CW'(1));
  assign free_now  = handshake & last_beat;

  // The write bank is usable when empty, or when its final beat leaves this
  // very cycle: the last entry was already fetched, so overwriting it is safe.
  assign wr_bank_avail = !bank_full[wr_bank] || (free_now && (rd_bank == wr_bank));

  assign has_room    = (wr_ptr < CW'(DEPTH));
  assign wr_en       = p_valid & has_room & wr_bank_avail;
  assign blocked_now = p_valid & has_room & !wr_bank_avail;
  assign trunc_final = wr_trunc | (p_valid & !has_room);

  // Length including any word arriving together with last_out.
  assign frame_len = wr_ptr + CW'(p_valid & has_room);
  assign frame_end = last_out & (frame_len != '0);
  assign publish   = frame_end & !wr_blocked & wr_bank_avail;
  assign drop      = frame_end & !publish;

  assign wr_addr = {wr_bank, wr_ptr[AW-1:0]};
  assign rd_addr = {rd_bank, rd_ptr[AW-1:0]};

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    advance = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // A frame published into the bank we read next starts replay at once.
        if (bank_full[rd_bank] || (publish && (wr_bank == rd_bank))) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_SHOW;
      end
      S_SHOW: begin
        if (handshake) begin
          if (last_beat) begin
            finish  = 1'b1;
            state_d = S_IDLE;
          end else begin
            advance = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: the peak storage carries no reset; bank_full alone decides what is
  // valid, so clearing the flags discards all content in one cycle.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= p_i_s;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register sees the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (areset) begin
      state_q       <= S_IDLE;
      wr_bank       <= 1'b0;
      wr_ptr        <= '0;
      wr_trunc      <= 1'b0;
      wr_blocked    <= 1'b0;
      bank_full     <= '0;
      bank_count[0] <= '0;
      bank_count[1] <= '0;
      bank_trunc    <= '0;
      rd_bank       <= 1'b0;
      rd_ptr        <= '0;
      rd_word       <= '0;
      rd_count_q    <= '0;
      rd_trunc_q    <= 1'b0;
      frame_drop_q  <= 1'b0;
      drop_cnt      <= '0;
    end else begin
      state_q      <= state_d;
      frame_drop_q <= drop;

      if (drop && (drop_cnt != {CNT_W{1'b1}})) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end

      // Write side bookkeeping
      if (frame_end) begin
        wr_ptr     <= '0;
        wr_trunc   <= 1'b0;
        wr_blocked <= 1'b0;
        if (publish) begin
          wr_bank <= ~wr_bank;
        end
      end else if (p_valid) begin
        if (has_room) begin
          wr_ptr <= wr_ptr + CW'(1);
        end else begin
          wr_trunc <= 1'b1;
        end
        if (blocked_now) begin
          wr_blocked <= 1'b1;
        end
      end

      // Release before publish: when both hit the same bank the publish wins.
      if (free_now) begin
        bank_full[rd_bank] <= 1'b0;
      end
      if (publish) begin
        bank_full[wr_bank]  <= 1'b1;
        bank_count[wr_bank] <= frame_len;
        bank_trunc[wr_bank] <= trunc_final;
      end

      // Read side
      if (state_q == S_FETCH) begin
        rd_word <= mem[rd_addr];
        // Frame descriptor is captured on the first fetch and held to the end.
        if (rd_ptr == '0) begin
          rd_count_q <= bank_count[rd_bank];
          rd_trunc_q <= bank_trunc[rd_bank];
        end
      end
      if (advance) begin
        rd_ptr <= rd_ptr + CW'(1);
      end
      if (finish) begin
        rd_ptr  <= '0;
        rd_bank <= ~rd_bank;
      end
    end
  end

  assign rd_peak        = rd_word[31 -: VALUE_WIDTH];
  assign rd_side        = rd_word[SIDE_BIT];
  assign rd_index       = rd_word[INDEX_WIDTH-1:0];
  assign rd_last        = rd_valid & last_beat;
  assign rd_count       = rd_count_q;
  assign rd_trunc       = rd_trunc_q;
  assign frame_drop     = frame_drop_q;
  assign frames_dropped = drop_cnt;

endmodule

// File: tb/tb_peak_list_reader.sv
// -----------------------------------------------------------------------------
// tb_peak_list_reader
//
// Directed bench for peak_list_reader. A frame-level model (queues of expected
// beats, count of frames held by the reader) predicts every output each cycle;
// directed scenarios add literal expectations on latency, beat counts,
// truncation, drops and reset.
// -----------------------------------------------------------------------------
module tb_peak_list_reader;

  localparam int VW    = 16;
  localparam int IW    = 15;
  localparam int DEPTH = 64;
  localparam int CNT_W = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            areset = 1'b1;
  logic            p_valid = 1'b0;
  logic [31:0]     p_i_s = '0;
  logic            last_out = 1'b0;
  logic            rd_valid;
  logic            rd_ready = 1'b0;
  logic [VW-1:0]   rd_peak;
  logic            rd_side;
  logic [IW-1:0]   rd_index;
  logic            rd_last;
  logic [CW-1:0]   rd_count;
  logic            rd_trunc;
  logic            frame_drop;
  logic [CNT_W-1:0] frames_dropped;

  peak_list_reader #(
    .VALUE_WIDTH(VW), .INDEX_WIDTH(IW), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .areset(areset), .p_valid(p_valid), .p_i_s(p_i_s),
    .last_out(last_out), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_peak(rd_peak), .rd_side(rd_side), .rd_index(rd_index),
    .rd_last(rd_last), .rd_count(rd_count), .rd_trunc(rd_trunc),
    .frame_drop(frame_drop), .frames_dropped(frames_dropped)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Frame-level model
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [VW-1:0] peak;
    logic          side;
    logic [IW-1:0] idx;
    logic          last;
    logic [CW-1:0] count;
    logic          trunc;
  } beat_t;

  beat_t            exp_q[$];   // beats of frames already handed to the reader
  beat_t            cur_q[$];   // stored words of the frame being collected
  bit               cur_trunc = 0;
  bit               cur_blocked = 0;
  int               held = 0;   // frames the reader still holds (max 2 banks)
  logic [CNT_W-1:0] m_dropped = '0;
  logic             m_drop = 1'b0;

  // Observations for literal checks
  int               beats_acc = 0;
  int               drop_pulses = 0;
  logic [IW-1:0]    last_idx = '0;
  logic             last_trunc_seen = 1'b0;
  logic [CW-1:0]    last_count_seen = '0;

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      // Compare the DUT against the model state for this cycle.
      check("frames_dropped", frames_dropped, m_dropped);
      check("frame_drop", frame_drop, m_drop);
      if (frame_drop) drop_pulses++;
      if (exp_q.size() == 0) begin
        check("rd_valid_idle", rd_valid, 0);
      end else if (rd_valid) begin
        check("rd_peak",  rd_peak,  exp_q[0].peak);
        check("rd_side",  rd_side,  exp_q[0].side);
        check("rd_index", rd_index, exp_q[0].idx);
        check("rd_last",  rd_last,  exp_q[0].last);
        check("rd_count", rd_count, exp_q[0].count);
        check("rd_trunc", rd_trunc, exp_q[0].trunc);
      end

      // Advance the model over the coming clock edge.
      if (areset) begin
        exp_q.delete();
        cur_q.delete();
        cur_trunc   = 0;
        cur_blocked = 0;
        held        = 0;
        m_dropped   = '0;
        m_drop      = 1'b0;
      end else begin
        bit    free_now;
        bit    room;
        beat_t b;
        free_now = rd_valid && rd_ready && (exp_q.size() > 0) && exp_q[0].last;
        room     = (held < 2) || free_now;
        m_drop   = 1'b0;
        if (p_valid) begin
          if (cur_q.size() < DEPTH) begin
            b = '0;
            b.peak = p_i_s[31:16];
            b.side = p_i_s[15];
            b.idx  = p_i_s[14:0];
            if (!room) cur_blocked = 1;
            cur_q.push_back(b);
          end else begin
            cur_trunc = 1;
          end
        end
        if (last_out && cur_q.size() > 0) begin
          if (!cur_blocked && room) begin
            for (int i = 0; i < cur_q.size(); i++) begin
              b       = cur_q[i];
              b.last  = (i == cur_q.size() - 1);
              b.count = CW'(cur_q.size());
              b.trunc = cur_trunc;
              exp_q.push_back(b);
            end
            held++;
          end else begin
            m_drop = 1'b1;
            if (m_dropped != {CNT_W{1'b1}}) m_dropped = m_dropped + 1'b1;
          end
          cur_q.delete();
          cur_trunc   = 0;
          cur_blocked = 0;
        end
        if (rd_valid && rd_ready && exp_q.size() > 0) begin
          beats_acc++;
          if (rd_last) begin
            last_idx        = rd_index;
            last_trunc_seen = rd_trunc;
            last_count_seen = rd_count;
          end
          b = exp_q.pop_front();
          if (b.last) held--;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic send(input logic [VW-1:0] pk, input logic s, input logic [IW-1:0] ix,
                      input logic l);
    @(posedge clk); #1;
    p_valid  = 1'b1;
    p_i_s    = {pk, s, ix};
    last_out = l;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      p_valid  = 1'b0;
      last_out = 1'b0;
    end
  endtask

  task automatic wait_valid(input int maxc);
    int c = 0;
    @(negedge clk);
    while (!rd_valid && c < maxc) begin
      @(negedge clk);
      c++;
    end
    check("wait_valid", rd_valid, 1);
  endtask

  task automatic accept_one();
    wait_valid(20);
    @(posedge clk); #1 rd_ready = 1'b1;
    @(posedge clk); #1 rd_ready = 1'b0;
  endtask

  task automatic drain(input int maxc);
    int c = 0;
    while ((exp_q.size() != 0 || rd_valid) && c < maxc) begin
      @(negedge clk);
      c++;
    end
    check("drain_done", exp_q.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Directed scenarios
  // ---------------------------------------------------------------------------
  initial begin
    int b0, d0;
    logic [VW-1:0] pk5 [5];
    pk5[0] = 16'h0028; pk5[1] = 16'h0034; pk5[2] = 16'h0A34;
    pk5[3] = 16'h0514; pk5[4] = 16'h00C3;

    // Reset state
    repeat (3) @(posedge clk);
    #1 areset = 1'b0;
    @(negedge clk);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_peak", rd_peak, 0);
    check("rst_rd_index", rd_index, 0);
    check("rst_rd_last", rd_last, 0);
    check("rst_rd_count", rd_count, 0);
    check("rst_rd_trunc", rd_trunc, 0);
    check("rst_frame_drop", frame_drop, 0);
    check("rst_frames_dropped", frames_dropped, 0);

    // 1: five-word frame, latency and order
    rd_ready = 1'b1;
    b0 = beats_acc;
    for (int i = 0; i < 5; i++) send(pk5[i], 1'(i % 2), IW'(i + 1), i == 4);
    idle(1);
    @(negedge clk);
    check("t1_valid_after_1", rd_valid, 0);
    @(negedge clk);
    check("t1_valid_after_2", rd_valid, 1);
    check("t1_first_peak", rd_peak, 16'h0028);
    check("t1_first_index", rd_index, 1);
    check("t1_count", rd_count, 5);
    check("t1_trunc", rd_trunc, 0);
    drain(100);
    check("t1_beats", beats_acc - b0, 5);
    check("t1_last_index", last_idx, 5);

    // 2: stall on beat 2 for 10 cycles
    rd_ready = 1'b0;
    b0 = beats_acc;
    for (int i = 0; i < 5; i++) send(16'h0100 + 16'(i), 1'(i % 2), IW'(i + 11), i == 4);
    idle(1);
    wait_valid(20);
    check("t2_beat1_index", rd_index, 11);
    accept_one();
    wait_valid(20);
    repeat (10) begin
      @(negedge clk);
      check("t2_hold_index", rd_index, 12);
      check("t2_hold_peak", rd_peak, 16'h0101);
      check("t2_hold_valid", rd_valid, 1);
    end
    @(posedge clk); #1 rd_ready = 1'b1;
    drain(100);
    check("t2_beats", beats_acc - b0, 5);
    check("t2_last_index", last_idx, 15);

    // 3: 70 words into a 64-deep bank
    b0 = beats_acc;
    for (int i = 0; i < 70; i++) send(16'(i * 3 + 1), 1'(i % 2), IW'(i + 1), i == 69);
    idle(1);
    drain(400);
    check("t3_beats", beats_acc - b0, 64);
    check("t3_last_index", last_idx, 64);
    check("t3_trunc", last_trunc_seen, 1);
    check("t3_count", last_count_seen, 64);

    // 4: A stalled, B fills the other bank, C is dropped
    rd_ready = 1'b0;
    b0 = beats_acc;
    d0 = drop_pulses;
    for (int i = 0; i < 4; i++) send(16'h0A00 + 16'(i), 1'b0, IW'(100 + i), i == 3);
    idle(1);
    wait_valid(20);
    for (int i = 0; i < 3; i++) send(16'h0B00 + 16'(i), 1'b1, IW'(200 + i), i == 2);
    for (int i = 0; i < 2; i++) send(16'h0C00 + 16'(i), 1'b0, IW'(300 + i), i == 1);
    idle(3);
    check("t4_frames_dropped", frames_dropped, 1);
    check("t4_drop_pulses", drop_pulses - d0, 1);
    @(posedge clk); #1 rd_ready = 1'b1;
    drain(200);
    check("t4_beats", beats_acc - b0, 7);
    check("t4_last_index", last_idx, 202);

    // 5a: empty frame
    d0 = drop_pulses;
    @(posedge clk); #1 last_out = 1'b1;
    idle(5);
    check("t5a_no_valid", rd_valid, 0);
    check("t5a_drop_pulses", drop_pulses - d0, 0);
    check("t5a_frames_dropped", frames_dropped, 1);

    // 5b: last_out of C coincides with A's final accepted beat while B waits
    rd_ready = 1'b0;
    b0 = beats_acc;
    send(16'h0D00, 1'b0, IW'(400), 1'b0);
    send(16'h0D01, 1'b1, IW'(401), 1'b1);
    send(16'h0E00, 1'b0, IW'(500), 1'b0);
    send(16'h0E01, 1'b1, IW'(501), 1'b1);
    idle(1);
    accept_one();
    wait_valid(20);
    check("t5b_a_last_shown", rd_last, 1);
    @(posedge clk); #1;
    rd_ready = 1'b1;
    p_valid  = 1'b1;
    p_i_s    = {16'h0F00, 1'b1, IW'(600)};
    last_out = 1'b1;
    idle(1);
    drain(200);
    check("t5b_drop_pulses", drop_pulses - d0, 0);
    check("t5b_beats", beats_acc - b0, 5);
    check("t5b_last_index", last_idx, 600);

    // 6: reset during beat 3 of 8, then a clean frame
    rd_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(16'h0700 + 16'(i), 1'(i % 2), IW'(700 + i), i == 7);
    idle(1);
    accept_one();
    accept_one();
    wait_valid(20);
    check("t6_beat3_index", rd_index, 702);
    @(posedge clk); #1 areset = 1'b1;
    @(posedge clk); #1 areset = 1'b0;
    @(negedge clk);
    check("t6_valid_after_reset", rd_valid, 0);
    check("t6_dropped_after_reset", frames_dropped, 0);
    rd_ready = 1'b1;
    b0 = beats_acc;
    for (int i = 0; i < 4; i++) send(16'h0800 + 16'(i), 1'b0, IW'(800 + i), i == 3);
    idle(1);
    drain(100);
    check("t6_beats", beats_acc - b0, 4);
    check("t6_last_index", last_idx, 803);
    check("t6_count", last_count_seen, 4);

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
